// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper driver, the phase decoder and benches.
//   - Full-step coil codes {A,B,C,D} and the de-energised idle code.
//   - Position class encodings reported on o_pos.
//   - Decoder state enum and a helper that classifies a 4-bit coil code.
package stepper_pkg;

    localparam logic [3:0] PH_S1   = 4'b1100;
    localparam logic [3:0] PH_S2   = 4'b0110;
    localparam logic [3:0] PH_S3   = 4'b0011;
    localparam logic [3:0] PH_S4   = 4'b1001;
    localparam logic [3:0] PH_IDLE = 4'b0000;

    localparam logic [1:0] POS_HOME  = 2'b00;
    localparam logic [1:0] POS_LIMIT = 2'b01;
    localparam logic [1:0] POS_MID   = 2'b10;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } dec_state_t;

    typedef enum logic [1:0] {
        CODE_VALID   = 2'b00,
        CODE_IDLE    = 2'b01,
        CODE_ILLEGAL = 2'b10
    } code_kind_t;

    typedef struct packed {
        code_kind_t kind;
        logic [1:0] idx;
    } code_info_t;

    // Classify a coil code; idx is only meaningful for CODE_VALID.
    function automatic code_info_t decode_phase(input logic [3:0] code);
        code_info_t info;
        info.kind = CODE_ILLEGAL;
        info.idx  = 2'd0;
        case (code)
            PH_S1:   begin info.kind = CODE_VALID; info.idx = 2'd0; end
            PH_S2:   begin info.kind = CODE_VALID; info.idx = 2'd1; end
            PH_S3:   begin info.kind = CODE_VALID; info.idx = 2'd2; end
            PH_S4:   begin info.kind = CODE_VALID; info.idx = 2'd3; end
            PH_IDLE: begin info.kind = CODE_IDLE;  info.idx = 2'd0; end
            default: begin info.kind = CODE_ILLEGAL; info.idx = 2'd0; end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/stepper_phase_decoder_if.sv
// Signal bundle between a coil-pattern source and the phase decoder.
//   i_phase   : coil lines {A,B,C,D} (asynchronous to the decoder clock)
//   i_clr_err : synchronous clear of the sticky error flags
//   o_*       : decoded position, direction, step pulse, lock and errors
// master = stimulus/monitor side, slave = decoder side.
interface stepper_phase_decoder_if #(
    parameter int COUNT_W = 8
);
    logic [3:0]         i_phase;
    logic               i_clr_err;
    logic [COUNT_W-1:0] o_count;
    logic [1:0]         o_pos;
    logic               o_dir;
    logic               o_step;
    logic               o_locked;
    logic               o_err_illegal;
    logic               o_err_skip;
    logic               o_err_range;

    modport master (
        output i_phase, i_clr_err,
        input  o_count, o_pos, o_dir, o_step, o_locked,
               o_err_illegal, o_err_skip, o_err_range
    );

    modport slave (
        input  i_phase, i_clr_err,
        output o_count, o_pos, o_dir, o_step, o_locked,
               o_err_illegal, o_err_skip, o_err_range
    );
endinterface

// File: rtl/stepper_phase_decoder_phase_filter.sv
// Two-flop synchroniser plus stability filter for the four coil lines.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_phase        : raw coil lines
//   o_code         : filtered code (accepted after FILTER_CYCLES stable cycles)
//   o_changed      : one-cycle strobe in the cycle o_code takes a new value
module phase_filter #(
    parameter int FILTER_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_phase,
    output logic [3:0] o_code,
    output logic       o_changed
);

    localparam int CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("phase_filter: FILTER_CYCLES must be at least 1");
    end

    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       sync2_d_r;
    logic [3:0]       code_r;
    logic             changed_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] run_s;
    logic             accept_s;

    // Length of the current run of identical synchronised values, saturating.
    always_comb begin
        run_s    = CNT_W'(1'b1);
        accept_s = 1'b0;
        if (sync2_r != sync2_d_r) begin
            run_s = CNT_W'(1'b1);
        end else if (cnt_r == CNT_MAX) begin
            run_s = CNT_MAX;
        end else begin
            run_s = cnt_r + CNT_W'(1'b1);
        end
        accept_s = (sync2_r != code_r) && (run_s >= CNT_MAX);
    end

    // Synchroniser, run counter and filtered-code register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r   <= 4'b0000;
            sync2_r   <= 4'b0000;
            sync2_d_r <= 4'b0000;
            code_r    <= 4'b0000;
            changed_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync1_r   <= i_phase;
            sync2_r   <= sync1_r;
            sync2_d_r <= sync2_r;
            if (accept_s) begin
                code_r    <= sync2_r;
                changed_r <= 1'b1;
                cnt_r     <= '0;
            end else if (sync2_r == code_r) begin
                // Back at the accepted value: any pending candidate is dropped.
                changed_r <= 1'b0;
                cnt_r     <= '0;
            end else begin
                changed_r <= 1'b0;
                cnt_r     <= run_s;
            end
        end
    end

    assign o_code    = code_r;
    assign o_changed = changed_r;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Full-step bipolar coil-pattern reader.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : i_phase/i_clr_err in; o_count, o_pos, o_dir, o_step,
//                    o_locked and sticky o_err_illegal/o_err_skip/o_err_range out
// Filters the coil lines, decodes step direction against the last accepted
// phase index, tracks position in 0..COUNT_LIMIT and flags anomalies.
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int FILTER_CYCLES = 2,
    parameter int COUNT_W       = 8,
    parameter int COUNT_LIMIT   = 200
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    stepper_phase_decoder_if.slave   bus
);

    if ((COUNT_LIMIT < 1) || (COUNT_LIMIT > ((1 << COUNT_W) - 1))) begin : g_bad_limit
        $error("stepper_phase_decoder: COUNT_LIMIT must be in 1..2**COUNT_W-1");
    end

    localparam logic [COUNT_W-1:0] LIMIT_C = COUNT_W'(COUNT_LIMIT);
    localparam logic [COUNT_W-1:0] ZERO_C  = '0;

    logic [3:0]   code_s;
    logic         changed_s;
    code_info_t   info_s;
    logic [1:0]   delta_s;

    dec_state_t         state_r, state_n;
    logic [1:0]         ref_r, ref_n;
    logic [COUNT_W-1:0] count_r, count_n;
    logic [1:0]         pos_r, pos_n;
    logic               dir_r, dir_n;
    logic               step_r, step_n;
    logic               locked_r;
    logic               err_illegal_r, err_skip_r, err_range_r;
    logic               set_illegal_s, set_skip_s, set_range_s;

    phase_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_phase   (bus.i_phase),
        .o_code    (code_s),
        .o_changed (changed_s)
    );

    // Event decode: acts only in the cycle after the filtered code changed.
    always_comb begin
        info_s        = decode_phase(code_s);
        delta_s       = info_s.idx - ref_r;   // 2-bit wrap gives mod-4 distance
        state_n       = state_r;
        ref_n         = ref_r;
        count_n       = count_r;
        dir_n         = dir_r;
        step_n        = 1'b0;
        set_illegal_s = 1'b0;
        set_skip_s    = 1'b0;
        set_range_s   = 1'b0;
        if (changed_s) begin
            case (state_r)
                ACQ: begin
                    case (info_s.kind)
                        CODE_VALID: begin
                            ref_n   = info_s.idx;
                            state_n = TRACK;
                        end
                        CODE_ILLEGAL: set_illegal_s = 1'b1;
                        default:      state_n = ACQ;
                    endcase
                end
                TRACK: begin
                    case (info_s.kind)
                        CODE_VALID: begin
                            ref_n = info_s.idx;
                            case (delta_s)
                                2'd1: begin
                                    step_n = 1'b1;
                                    dir_n  = 1'b1;
                                    if (count_r == LIMIT_C) begin
                                        set_range_s = 1'b1;
                                    end else begin
                                        count_n = count_r + COUNT_W'(1'b1);
                                    end
                                end
                                2'd3: begin
                                    step_n = 1'b1;
                                    dir_n  = 1'b0;
                                    if (count_r == ZERO_C) begin
                                        set_range_s = 1'b1;
                                    end else begin
                                        count_n = count_r - COUNT_W'(1'b1);
                                    end
                                end
                                2'd2:    set_skip_s = 1'b1;
                                default: step_n = 1'b0;
                            endcase
                        end
                        CODE_ILLEGAL: begin
                            set_illegal_s = 1'b1;
                            state_n       = ACQ;
                        end
                        // Idle keeps ref_r so the next valid code is judged against it.
                        default: state_n = TRACK;
                    endcase
                end
                default: state_n = ACQ;
            endcase
        end else begin
            state_n = state_r;
        end

        if (count_n == ZERO_C) begin
            pos_n = POS_HOME;
        end else if (count_n == LIMIT_C) begin
            pos_n = POS_LIMIT;
        end else begin
            pos_n = POS_MID;
        end
    end

    // Decoder state, position and registered outputs; error set beats clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ACQ;
            ref_r         <= 2'd0;
            count_r       <= '0;
            pos_r         <= POS_HOME;
            dir_r         <= 1'b1;
            step_r        <= 1'b0;
            locked_r      <= 1'b0;
            err_illegal_r <= 1'b0;
            err_skip_r    <= 1'b0;
            err_range_r   <= 1'b0;
        end else begin
            state_r       <= state_n;
            ref_r         <= ref_n;
            count_r       <= count_n;
            pos_r         <= pos_n;
            dir_r         <= dir_n;
            step_r        <= step_n;
            locked_r      <= (state_n == TRACK);
            err_illegal_r <= set_illegal_s | (err_illegal_r & ~bus.i_clr_err);
            err_skip_r    <= set_skip_s    | (err_skip_r    & ~bus.i_clr_err);
            err_range_r   <= set_range_s   | (err_range_r   & ~bus.i_clr_err);
        end
    end

    assign bus.o_count       = count_r;
    assign bus.o_pos         = pos_r;
    assign bus.o_dir         = dir_r;
    assign bus.o_step        = step_r;
    assign bus.o_locked      = locked_r;
    assign bus.o_err_illegal = err_illegal_r;
    assign bus.o_err_skip    = err_skip_r;
    assign bus.o_err_range   = err_range_r;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Self-checking bench for stepper_phase_decoder: directed scenarios followed
// by a random step walk and a full-travel run, all checked against a
// step-level reference model of the coil-pattern rules.
module tb_stepper_phase_decoder;
    import stepper_pkg::*;

    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stepper_phase_decoder_if #(.COUNT_W(8)) bus ();

    stepper_phase_decoder #(
        .FILTER_CYCLES (2),
        .COUNT_W       (8),
        .COUNT_LIMIT   (LIMIT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [3:0] phases [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    logic [3:0] m_last;
    int  m_count, m_ref;
    bit  m_locked, m_dir, m_ill, m_skip, m_rng, m_step;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_last = 4'b0000; m_count = 0; m_ref = 0;
        m_locked = 0; m_dir = 1; m_ill = 0; m_skip = 0; m_rng = 0; m_step = 0;
    endfunction

    function automatic int idx_of(input logic [3:0] code);
        if (code == 4'b0000) return -1;
        for (int k = 0; k < 4; k++) if (phases[k] == code) return k;
        return -2;
    endfunction

    // Apply one accepted code change to the model.
    function automatic void model_apply(input logic [3:0] code);
        int idx, d;
        m_step = 0;
        idx = idx_of(code);
        m_last = code;
        if (idx == -2) begin
            m_ill = 1;
            m_locked = 0;
        end else if (idx >= 0) begin
            if (!m_locked) begin
                m_locked = 1;
                m_ref = idx;
            end else begin
                d = (idx - m_ref + 4) % 4;
                m_ref = idx;
                if (d == 1) begin
                    m_step = 1; m_dir = 1;
                    if (m_count == LIMIT) m_rng = 1; else m_count++;
                end else if (d == 3) begin
                    m_step = 1; m_dir = 0;
                    if (m_count == 0) m_rng = 1; else m_count--;
                end else if (d == 2) begin
                    m_skip = 1;
                end
            end
        end
    endfunction

    function automatic int pos_of(input int c);
        if (c == 0) return 0;
        if (c == LIMIT) return 1;
        return 2;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".count"},  32'(bus.o_count), 32'(m_count));
        chk({tag, ".pos"},    32'(bus.o_pos), 32'(pos_of(m_count)));
        chk({tag, ".dir"},    32'(bus.o_dir), 32'(m_dir));
        chk({tag, ".locked"}, 32'(bus.o_locked), 32'(m_locked));
        chk({tag, ".ill"},    32'(bus.o_err_illegal), 32'(m_ill));
        chk({tag, ".skip"},   32'(bus.o_err_skip), 32'(m_skip));
        chk({tag, ".range"},  32'(bus.o_err_range), 32'(m_rng));
    endtask

    // Drive a code after a rising edge, check the step pulse edge by edge.
    task automatic drive_code(input string tag, input logic [3:0] code, input int hold);
        bit exp_step;
        @(posedge clk); #1;
        bus.i_phase = code;
        exp_step = 0;
        if (code != m_last) begin
            model_apply(code);
            exp_step = m_step;
        end
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, ".step"}, 32'(bus.o_step), 32'((i == 5) && exp_step));
        end
        check_all(tag);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 bus.i_clr_err = 1'b1;
        @(posedge clk); #1 bus.i_clr_err = 1'b0;
        m_ill = 0; m_skip = 0; m_rng = 0;
        @(negedge clk);
        check_all("clr");
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".count"},  32'(bus.o_count), 32'd0);
        chk({tag, ".pos"},    32'(bus.o_pos), 32'(POS_HOME));
        chk({tag, ".dir"},    32'(bus.o_dir), 32'd1);
        chk({tag, ".step"},   32'(bus.o_step), 32'd0);
        chk({tag, ".locked"}, 32'(bus.o_locked), 32'd0);
        chk({tag, ".errs"},   32'({bus.o_err_illegal, bus.o_err_skip, bus.o_err_range}), 32'd0);
    endtask

    initial begin
        int r, nxt;
        bus.i_phase   = 4'b0000;
        bus.i_clr_err = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Forward sequence: lock, then four forward steps.
        drive_code("fwd0", PH_S1, 10);
        drive_code("fwd1", PH_S2, 10);
        drive_code("fwd2", PH_S3, 10);
        drive_code("fwd3", PH_S4, 10);
        drive_code("fwd4", PH_S1, 10);

        // Backward sequence down to 0, last one hits the range guard.
        drive_code("bwd0", PH_S4, 10);
        drive_code("bwd1", PH_S3, 10);
        drive_code("bwd2", PH_S2, 10);
        drive_code("bwd3", PH_S1, 10);
        drive_code("bwd4", PH_S4, 10);

        // Single-cycle glitch must be filtered out.
        drive_code("pre_glitch", PH_S1, 10);
        @(posedge clk); #1 bus.i_phase = PH_S2;
        @(posedge clk); #1 bus.i_phase = PH_S1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("glitch.step", 32'(bus.o_step), 32'd0);
        end
        check_all("glitch");

        // Skip, illegal, relock, clear.
        drive_code("skip", PH_S3, 10);
        drive_code("illegal", 4'b1010, 10);
        drive_code("relock", PH_S2, 10);
        pulse_clr();

        // Idle hold keeps the reference index.
        drive_code("idle", PH_IDLE, 20);
        drive_code("after_idle", PH_S3, 10);

        // Random walk.
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 11));
            if (r <= 5)      nxt = (m_ref + 1) % 4;
            else if (r <= 8) nxt = (m_ref + 3) % 4;
            else if (r == 9) nxt = (m_ref + 2) % 4;
            else             nxt = -1;
            if (nxt < 0) begin
                if (m_last != PH_IDLE) drive_code("rnd_idle", PH_IDLE, 8);
                else drive_code("rnd_ret", phases[m_ref], 8);
            end else begin
                drive_code("rnd", phases[nxt], 8);
            end
        end
        if (m_last == PH_IDLE) drive_code("rnd_end", phases[(m_ref + 1) % 4], 8);
        pulse_clr();

        // Run up to the top of travel, then one more step.
        for (int k = 0; k < 260 && m_count < LIMIT; k++)
            drive_code("travel", phases[(m_ref + 1) % 4], 7);
        chk("limit.count", 32'(bus.o_count), 32'(LIMIT));
        chk("limit.pos", 32'(bus.o_pos), 32'(POS_LIMIT));
        drive_code("over", phases[(m_ref + 1) % 4], 10);
        chk("over.range", 32'(bus.o_err_range), 32'd1);

        // Asynchronous reset mid-hold, away from the clock edge.
        @(posedge clk); #1 bus.i_phase = phases[(m_ref + 1) % 4];
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        model_apply(bus.i_phase);
        repeat (10) @(negedge clk);
        check_all("reacq");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Reader for the 4-lead full-step bipolar coil pattern that the stepper driver emits (A B C D: 1100, 0110, 0011, 1001).
- Synchronises and filters the four phase lines, then decodes step direction.
- Tracks absolute step position with the same position encoding the driver reports.
- Flags illegal codes, skipped steps and range violations, so the motor path can be closed-loop checked on board or in simulation.

Parameters:
- FILTER_CYCLES, 2: consecutive cycles a synchronised phase code must be stable before it is accepted (min 1).
- COUNT_W, 8: width of the position counter.
- COUNT_LIMIT, 200: top-of-travel position in steps (200 steps = 1 revolution).

Ports:
- i_clk  in  1  single system clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_phase  in  4  coil lines {A,B,C,D}, asynchronous to i_clk.
- i_clr_err  in  1  synchronous clear of the sticky error flags.
- o_count  out  COUNT_W  decoded step position, 0..COUNT_LIMIT.
- o_pos  out  2  position class: 00 at 0, 01 at COUNT_LIMIT, 10 otherwise.
- o_dir  out  1  direction of the last accepted step: 1 forward, 0 backward.
- o_step  out  1  one-cycle pulse per accepted step.
- o_locked  out  1  high while in TRACK.
- o_err_illegal  out  1  sticky; a non-phase, non-idle code was accepted.
- o_err_skip  out  1  sticky; a two-step jump was seen.
- o_err_range  out  1  sticky; a step was attempted beyond 0 or COUNT_LIMIT.

Behaviour:
- Reset (async assert, sync release):
  - o_count=0, o_pos=00, o_dir=1, o_step=0, o_locked=0, all error flags 0.
  - State ACQ; filter registers and synchroniser cleared to 0000.
- Input path:
  - 2-flop synchroniser on i_phase.
  - Stability counter: the filtered code takes the synchronised value once that value has differed from the filtered code and been constant for FILTER_CYCLES consecutive cycles.
  - Any change of the synchronised value restarts the count.
- Decode of the filtered code:
  - 1100 -> idx 0, 0110 -> idx 1, 0011 -> idx 2, 1001 -> idx 3.
  - 0000 -> IDLE (de-energised).
  - All other codes are ILLEGAL.
- Events: evaluated only in the cycle after the filtered code changes. Registered outputs update one cycle later.
- Latency: a clean i_phase change held stable produces o_step exactly 3+FILTER_CYCLES rising edges after the first edge that samples it (FILTER_CYCLES=2 -> 5).
- FSM ACQ:
  - Valid idx -> store as ref_idx, go TRACK, no step, count unchanged.
  - IDLE -> stay.
  - ILLEGAL -> set o_err_illegal, stay.
- FSM TRACK, with delta = (idx - ref_idx) mod 4:
  - delta 1 -> forward step: o_step=1, o_dir=1, count+1.
  - delta 3 -> backward step: o_step=1, o_dir=0, count-1.
  - delta 2 -> set o_err_skip, ref_idx<=idx, no step, count unchanged.
  - delta 0 -> no action.
  - IDLE -> no action; ref_idx retained; the next valid code is compared against the retained ref_idx.
  - ILLEGAL -> set o_err_illegal, go ACQ, o_locked=0.
  - ref_idx<=idx on every valid code.
- Range:
  - Forward step at count==COUNT_LIMIT, or backward step at count==0: o_step and o_dir still report the step, count holds, o_err_range set.
  - Wrap-around of the count is forbidden.
- o_pos is a registered function of the updated count; it is valid in the same cycle as the new o_count.
- Counter arithmetic is COUNT_W unsigned. COUNT_LIMIT must be < 2**COUNT_W (elaboration check).
- Simultaneous i_clr_err and a new error in the same cycle: the set wins.
- i_clr_err does not affect count, state or ref_idx.
- Reset mid-operation: everything returns to reset values immediately; after release the block re-acquires with no step counted.

Decomposition:
- Shared package stepper_pkg, also used by the driver and the bench:
  - phase code constants PH_S1..PH_S4 and PH_IDLE;
  - o_pos encodings POS_HOME=00, POS_LIMIT=01, POS_MID=10;
  - decoder state enum ACQ/TRACK.
- One sub-module, phase_filter: synchroniser plus stability counter, parameter FILTER_CYCLES, outputs the filtered code and a one-cycle changed strobe.

Test Plan:
- Reset, then drive 1100 -> 0110 -> 0011 -> 1001 -> 1100, each held 10 cycles:
  - first code only locks (o_locked=1, o_count=0);
  - then 4 o_step pulses with o_dir=1, o_count=4, o_pos=10;
  - each pulse lands 5 edges after its change.
- From count 4, drive the backward sequence 1001, 0011, 0110, 1100, 1001: o_dir=0, count 4->3->2->1->0->0.
  - Last step sets o_err_range, o_pos=00, count stays 0.
- Glitch: 1100 -> 0110 for 1 cycle -> back to 1100 (FILTER_CYCLES=2) -> no o_step, count unchanged, no errors.
- Error cases:
  - 1100 -> 0011 -> o_err_skip=1, no step.
  - Then 1010 -> o_err_illegal=1, o_locked=0.
  - Then 0110 -> relock, no step.
  - Pulse i_clr_err -> both flags 0.
- Idle hold: 0110 -> 0000 (20 cycles) -> 0011 -> one forward step counted.
- Limit and reset:
  - 200 forward steps -> o_count=200, o_pos=01; a 201st step -> count holds 200, o_err_range=1.
  - Assert i_rst_n=0 mid-hold, off the clock edge -> all outputs return to reset values without waiting for a clock edge.
